// File: rtl/router_pkg.sv
// Shared types and header helpers for the 1xN byte-serial packet router.
// The header is {length, addr}, with the address in the low ADDR_W bits.
package router_pkg;

    localparam int DEF_DW         = 8;
    localparam int DEF_N_PORTS    = 3;
    localparam int DEF_ADDR_W     = 2;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_TIMEOUT    = 30;
    localparam int MAX_DW         = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EMPTY,
        ST_LOAD,
        ST_CHECK,
        ST_DROP
    } state_t;

    function automatic logic [MAX_DW-1:0] get_addr(input logic [MAX_DW-1:0] hdr, input int addr_w);
        return hdr & ((MAX_DW'(1) << addr_w) - MAX_DW'(1));
    endfunction

    // A shift by the full word width yields zero, so the mask still covers dw == MAX_DW.
    function automatic logic [MAX_DW-1:0] get_len(input logic [MAX_DW-1:0] hdr, input int dw,
                                                  input int addr_w);
        return (hdr & ((MAX_DW'(1) << dw) - MAX_DW'(1))) >> addr_w;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-port output FIFO with a registered read port and a stalled-reader timeout.
// Once the timeout is reached, the FIFO flushes to empty and o_data is left unchanged.
module router_fifo
    import router_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_data,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_flush
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [TW-1:0] r_tmr;
    logic [DW-1:0] r_data;
    logic          w_rd;
    logic          w_wr;
    logic          w_stall;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd    = i_rd_en && !o_empty;
    assign w_stall = !o_empty && !i_rd_en;
    assign o_flush = w_stall && (r_tmr == TMAX);
    // A read frees a slot in the same cycle, so a full FIFO can take a write alongside a read.
    assign w_wr    = i_wr_en && (!o_full || w_rd) && !o_flush;
    assign o_data  = r_data;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_tmr  <= '0;
            r_data <= '0;
        end else begin
            if (o_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr) r_wptr <= r_wptr + 1'b1;
                if (w_rd) begin
                    r_rptr <= r_rptr + 1'b1;
                    r_data <= r_mem[r_rptr[AW-1:0]];
                end
            end
            if (w_stall && !o_flush) r_tmr <= r_tmr + 1'b1;
            else                     r_tmr <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/router_1xn.sv
// 1xN packet router: header-addressed demux of a byte stream into per-port FIFOs.
// It also checks parity and length, and applies back-pressure through busy.
module router_1xn
    import router_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int N_PORTS    = DEF_N_PORTS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [DW-1:0]         data_in,
    input  logic                  pkt_valid,
    output logic                  busy,
    output logic                  error,
    input  logic [N_PORTS-1:0]    read_enb,
    output logic [N_PORTS-1:0]    vld_out,
    output logic [N_PORTS*DW-1:0] data_out
);

    localparam int LW = DW - ADDR_W;
    localparam logic [ADDR_W:0] NP = (ADDR_W + 1)'(N_PORTS);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_dest;
    logic [LW-1:0]       r_len;
    logic [LW-1:0]       r_cnt;
    logic [DW-1:0]       r_par;
    logic                r_fail;
    logic                r_error;

    logic [ADDR_W-1:0]   w_hdr_addr;
    logic [LW-1:0]       w_hdr_len;
    logic [ADDR_W-1:0]   w_sel;
    logic                w_addr_ok;
    logic [N_PORTS-1:0]  w_empty;
    logic [N_PORTS-1:0]  w_full;
    logic [N_PORTS-1:0]  w_flush;
    logic [N_PORTS-1:0]  w_wr;
    logic                w_dst_empty;
    logic                w_dst_full;
    logic                w_dst_flush;
    logic                w_hdr_acc;
    logic                w_pay_acc;
    logic                w_par_acc;
    logic                w_drop_end;
    logic                w_write;

    assign w_hdr_addr = ADDR_W'(get_addr(MAX_DW'(data_in), ADDR_W));
    assign w_hdr_len  = LW'(get_len(MAX_DW'(data_in), DW, ADDR_W));
    assign w_addr_ok  = ({1'b0, w_hdr_addr} < NP);
    // In IDLE the destination is still on data_in; after that it comes from the latched header.
    assign w_sel      = (r_state == ST_IDLE) ? w_hdr_addr : r_dest;

    always_comb begin
        w_dst_empty = 1'b1;
        w_dst_full  = 1'b0;
        w_dst_flush = 1'b0;
        w_wr        = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (w_sel == ADDR_W'(p)) begin
                w_dst_empty = w_empty[p];
                w_dst_full  = w_full[p];
                w_dst_flush = w_flush[p];
                w_wr[p]     = w_write;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b0;
        w_hdr_acc  = 1'b0;
        w_pay_acc  = 1'b0;
        w_par_acc  = 1'b0;
        w_drop_end = 1'b0;
        w_write    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (pkt_valid) begin
                    if (!w_addr_ok) begin
                        w_hdr_acc = 1'b1;
                        w_next    = ST_DROP;
                    end else if (w_dst_empty) begin
                        w_hdr_acc = 1'b1;
                        w_write   = 1'b1;
                        w_next    = ST_LOAD;
                    end else begin
                        busy   = 1'b1;
                        w_next = ST_WAIT_EMPTY;
                    end
                end
            end
            ST_WAIT_EMPTY: begin
                if (!w_dst_empty) begin
                    busy = 1'b1;
                end else begin
                    w_hdr_acc = 1'b1;
                    w_write   = 1'b1;
                    w_next    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy = w_dst_full;
                if (!w_dst_full) begin
                    w_write = 1'b1;
                    if (pkt_valid) begin
                        w_pay_acc = 1'b1;
                    end else begin
                        w_par_acc = 1'b1;
                        w_next    = ST_CHECK;
                    end
                end
                // Once the destination is flushed, the rest of the packet has nowhere to go.
                if (w_dst_flush && !w_par_acc) w_next = ST_DROP;
            end
            ST_CHECK: begin
                busy   = 1'b1;
                w_next = ST_IDLE;
            end
            ST_DROP: begin
                if (!pkt_valid) begin
                    w_drop_end = 1'b1;
                    w_next     = ST_CHECK;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dest  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_par   <= '0;
            r_fail  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && pkt_valid) r_dest <= w_hdr_addr;
            if (w_hdr_acc) begin
                r_len   <= w_hdr_len;
                r_cnt   <= '0;
                r_par   <= data_in;
                r_fail  <= 1'b0;
                r_error <= 1'b0;
            end
            if (w_pay_acc) begin
                r_cnt <= r_cnt + 1'b1;
                r_par <= r_par ^ data_in;
            end
            if (w_par_acc)  r_fail <= (r_par != data_in) || (r_cnt != r_len) || w_dst_flush;
            if (w_drop_end) r_fail <= 1'b1;
            if (r_state == ST_CHECK) r_error <= r_fail;
        end
    end

    genvar gp;
    generate
        for (gp = 0; gp < N_PORTS; gp++) begin : g_port
            router_fifo #(
                .DW        (DW),
                .FIFO_DEPTH(FIFO_DEPTH),
                .TIMEOUT   (TIMEOUT)
            ) u_fifo (
                .clock    (clock),
                .rst      (rst),
                .i_wr_en  (w_wr[gp]),
                .i_wr_data(data_in),
                .i_rd_en  (read_enb[gp]),
                .o_data   (data_out[gp*DW +: DW]),
                .o_empty  (w_empty[gp]),
                .o_full   (w_full[gp]),
                .o_flush  (w_flush[gp])
            );
        end
    endgenerate

    assign vld_out = ~w_empty;
    assign error   = r_error;

endmodule

// File: tb/tb_router_1xn.sv
// Bench for router_1xn: it drives packets against a per-port queue model of the expected FIFO contents.
// The reader-stall timeout and the read/data_out behaviour are modelled alongside those queues.
module tb_router_1xn;

    localparam int DW      = 8;
    localparam int N_PORTS = 3;
    localparam int ADDR_W  = 2;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    logic                  clock;
    logic                  rst;
    logic [DW-1:0]         data_in;
    logic                  pkt_valid;
    logic                  busy;
    logic                  error;
    logic [N_PORTS-1:0]    read_enb;
    logic [N_PORTS-1:0]    vld_out;
    logic [N_PORTS*DW-1:0] data_out;

    router_1xn #(
        .DW(DW), .N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .rst(rst), .data_in(data_in), .pkt_valid(pkt_valid), .busy(busy),
        .error(error), .read_enb(read_enb), .vld_out(vld_out), .data_out(data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_chk;
    int         n_fail;
    logic [7:0] q [N_PORTS][$];
    logic [7:0] dout_m [N_PORTS];
    int         stall [N_PORTS];
    int         rx_cnt [N_PORTS];
    int         rd_mode;
    bit         offering;
    int         cur_dest;
    bit         last_acc;
    int         cyc;
    int         hdr_cyc;
    logic [7:0] pkt_q [$];

    task automatic model_reset();
        for (int p = 0; p < N_PORTS; p++) begin
            q[p].delete();
            dout_m[p] = '0;
            stall[p]  = 0;
        end
    endtask

    // One clock cycle. It is entered and left at a falling edge; the model advances on the rising edge.
    task automatic tick();
        logic [N_PORTS-1:0] ren;
        logic [N_PORTS-1:0] rd;
        bit                 acc;
        bit                 flush;
        for (int p = 0; p < N_PORTS; p++) begin
            case (rd_mode)
                0:       ren[p] = 1'b0;
                1:       ren[p] = 1'b1;
                default: ren[p] = (stall[p] >= 10) || ($urandom_range(3) != 0);
            endcase
        end
        read_enb = ren;
        #1;
        for (int p = 0; p < N_PORTS; p++) begin
            n_chk++;
            if (vld_out[p] !== (q[p].size() != 0)) begin
                n_fail++;
                $display("FAIL vld_out[%0d]: got %b, expected %b", p, vld_out[p], q[p].size() != 0);
            end
            n_chk++;
            if (data_out[p*DW +: DW] !== dout_m[p]) begin
                n_fail++;
                $display("FAIL data_out[%0d]: got %h, expected %h", p, data_out[p*DW +: DW], dout_m[p]);
            end
            rd[p] = ren[p] && (q[p].size() != 0);
        end
        acc = !busy;
        @(posedge clock);
        cyc++;
        for (int p = 0; p < N_PORTS; p++) begin
            flush = 1'b0;
            if (q[p].size() != 0 && !ren[p]) begin
                if (stall[p] == TIMEOUT - 1) begin
                    flush    = 1'b1;
                    stall[p] = 0;
                end else begin
                    stall[p]++;
                end
            end else begin
                stall[p] = 0;
            end
            if (flush) begin
                q[p].delete();
            end else begin
                if (rd[p]) begin
                    dout_m[p] = q[p].pop_front();
                    rx_cnt[p]++;
                end
                if (acc && offering && cur_dest == p) q[p].push_back(data_in);
            end
        end
        last_acc = acc;
        @(negedge clock);
    endtask

    task automatic summary_and_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pv, output int waits);
        int n;
        n         = 0;
        data_in   = b;
        pkt_valid = pv;
        offering  = 1'b1;
        tick();
        while (!last_acc && n < 500) begin
            n++;
            tick();
        end
        offering = 1'b0;
        waits    = n;
        n_chk++;
        if (!last_acc) begin
            n_fail++;
            $display("FAIL accept_timeout: byte %h still held after %0d cycles, expected it accepted", b, n);
            summary_and_stop();
        end
    endtask

    task automatic build_pkt(input int addr, input int len, input bit bad);
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] b;
        logic [5:0] l6;
        logic [1:0] a2;
        l6  = 6'(len);
        a2  = 2'(addr);
        hdr = {l6, a2};
        pkt_q.delete();
        pkt_q.push_back(hdr);
        par = hdr;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            pkt_q.push_back(b);
            par ^= b;
        end
        pkt_q.push_back(bad ? (par ^ 8'h5A) : par);
    endtask

    task automatic finish_check(input bit exp_err);
        offering  = 1'b0;
        pkt_valid = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL check_busy: busy %b during check cycle, expected 1", busy);
        end
        tick();
        n_chk++;
        if (error !== exp_err) begin
            n_fail++;
            $display("FAIL error_flag: got %b, expected %b", error, exp_err);
        end
    endtask

    task automatic send_pkt(input bit exp_err, output int waits_tot);
        logic [7:0] h;
        int         a;
        int         w;
        h         = pkt_q[0];
        a         = int'(h[1:0]);
        cur_dest  = (a < N_PORTS) ? a : -1;
        waits_tot = 0;
        for (int i = 0; i < pkt_q.size(); i++) begin
            send_byte(pkt_q[i], (i != pkt_q.size() - 1), w);
            waits_tot += w;
            if (i == 0) begin
                hdr_cyc = cyc;
                n_chk++;
                if (error !== 1'b0) begin
                    n_fail++;
                    $display("FAIL error_clear: error %b after header accepted, expected 0", error);
                end
            end
        end
        finish_check(exp_err);
    endtask

    task automatic drain();
        int n;
        n         = 0;
        rd_mode   = 1;
        offering  = 1'b0;
        pkt_valid = 1'b0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        n_chk++;
        if (vld_out !== '0) begin
            n_fail++;
            $display("FAIL drain: vld_out %b after drain, expected 000", vld_out);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        data_in   = '0;
        pkt_valid = 1'b0;
        read_enb  = '0;
        offering  = 1'b0;
        cur_dest  = -1;
        rd_mode   = 0;
        model_reset();
        repeat (2) @(negedge clock);
        rst = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_chk++; if (error !== 1'b0)    begin n_fail++; $display("FAIL reset_error: got %b, expected 0", error); end
        n_chk++; if (vld_out !== '0)    begin n_fail++; $display("FAIL reset_vld: got %b, expected 0", vld_out); end
        n_chk++; if (data_out !== '0)   begin n_fail++; $display("FAIL reset_data: got %h, expected 0", data_out); end
        @(negedge clock);
    endtask

    task automatic test_basic();
        int r0, r1, r2, w;
        r0 = rx_cnt[0]; r1 = rx_cnt[1]; r2 = rx_cnt[2];
        rd_mode = 1;
        pkt_q   = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
        send_pkt(1'b0, w);
        drain();
        n_chk++;
        if (rx_cnt[1] - r1 !== 5) begin
            n_fail++;
            $display("FAIL basic_count: port1 delivered %0d bytes, expected 5", rx_cnt[1] - r1);
        end
        n_chk++;
        if ((rx_cnt[0] - r0) + (rx_cnt[2] - r2) !== 0) begin
            n_fail++;
            $display("FAIL basic_idle: ports 0/2 delivered %0d bytes, expected 0", (rx_cnt[0] - r0) + (rx_cnt[2] - r2));
        end
    endtask

    task automatic test_parity_err();
        int w;
        rd_mode = 1;
        pkt_q   = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'h00};
        send_pkt(1'b1, w);
        pkt_q   = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
        send_pkt(1'b0, w);
        drain();
    endtask

    task automatic test_bad_addr();
        int w;
        rd_mode = 1;
        pkt_q   = '{8'h03, 8'h11, 8'h22, 8'h00};
        send_pkt(1'b1, w);
        n_chk++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL drop_busy: %0d stall cycles while dropping, expected 0", w);
        end
        drain();
    endtask

    task automatic test_fill();
        int r, w;
        r        = rx_cnt[0];
        rd_mode  = 0;
        build_pkt(0, 63, 1'b0);
        cur_dest = 0;
        for (int i = 0; i < 65; i++) begin
            if (i == 16) begin
                data_in   = pkt_q[16];
                pkt_valid = 1'b1;
                offering  = 1'b1;
                repeat (3) begin
                    tick();
                    n_chk++;
                    if (last_acc !== 1'b0) begin
                        n_fail++;
                        $display("FAIL fill_busy: busy %b with port 0 full, expected 1", !last_acc);
                    end
                end
                rd_mode = 1;
            end
            send_byte(pkt_q[i], (i != 64), w);
            if (i < 16) begin
                n_chk++;
                if (w !== 0) begin
                    n_fail++;
                    $display("FAIL fill_early: byte %0d waited %0d cycles, expected 0", i, w);
                end
            end
        end
        finish_check(1'b0);
        drain();
        n_chk++;
        if (rx_cnt[0] - r !== 65) begin
            n_fail++;
            $display("FAIL fill_count: port0 delivered %0d bytes, expected 65", rx_cnt[0] - r);
        end
    endtask

    task automatic test_timeout();
        int n, w, r;
        rd_mode = 0;
        build_pkt(2, 2, 1'b0);
        send_pkt(1'b0, w);
        n = 0;
        while (vld_out[2] === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_chk++;
        if (cyc - hdr_cyc !== TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_cycle: vld_out[2] dropped %0d cycles after header, expected %0d", cyc - hdr_cyc, TIMEOUT);
        end
        r       = rx_cnt[2];
        rd_mode = 1;
        build_pkt(2, 1, 1'b0);
        send_pkt(1'b0, w);
        n_chk++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL timeout_reuse: %0d stall cycles after flush, expected 0", w);
        end
        drain();
        n_chk++;
        if (rx_cnt[2] - r !== 3) begin
            n_fail++;
            $display("FAIL timeout_reuse_count: port2 delivered %0d bytes, expected 3", rx_cnt[2] - r);
        end
    endtask

    task automatic test_reset_mid();
        int w, r;
        rd_mode = 1;
        build_pkt(1, 2, 1'b1);
        send_pkt(1'b1, w);
        rd_mode  = 0;
        build_pkt(0, 20, 1'b0);
        cur_dest = 0;
        for (int i = 0; i < 16; i++) send_byte(pkt_q[i], 1'b1, w);
        data_in   = pkt_q[16];
        pkt_valid = 1'b1;
        #2;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL premid_busy: got %b with port 0 full, expected 1", busy);
        end
        rst = 1'b1;
        #1;
        n_chk++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        n_chk++; if (error !== 1'b0)  begin n_fail++; $display("FAIL rstmid_error: got %b, expected 0", error); end
        n_chk++; if (vld_out !== '0)  begin n_fail++; $display("FAIL rstmid_vld: got %b, expected 0", vld_out); end
        n_chk++; if (data_out !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h, expected 0", data_out); end
        model_reset();
        offering  = 1'b0;
        pkt_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rst     = 1'b0;
        r       = rx_cnt[0];
        rd_mode = 1;
        build_pkt(0, 4, 1'b0);
        send_pkt(1'b0, w);
        drain();
        n_chk++;
        if (rx_cnt[0] - r !== 6) begin
            n_fail++;
            $display("FAIL rstmid_route: port0 delivered %0d bytes, expected 6", rx_cnt[0] - r);
        end
    endtask

    task automatic test_back_to_back();
        int w, a, l, exp_bytes, r_tot;
        bit bad;
        exp_bytes = 0;
        r_tot     = rx_cnt[0] + rx_cnt[1] + rx_cnt[2];
        rd_mode   = 2;
        for (int k = 0; k < 24; k++) begin
            a   = $urandom_range(3);
            l   = (k == 0) ? 0 : $urandom_range(20);
            bad = ($urandom_range(3) == 0);
            build_pkt(a, l, bad);
            send_pkt(bad || (a >= N_PORTS), w);
            if (a < N_PORTS) exp_bytes += l + 2;
        end
        drain();
        n_chk++;
        if (rx_cnt[0] + rx_cnt[1] + rx_cnt[2] - r_tot !== exp_bytes) begin
            n_fail++;
            $display("FAIL random_total: delivered %0d bytes, expected %0d", rx_cnt[0] + rx_cnt[1] + rx_cnt[2] - r_tot, exp_bytes);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        for (int p = 0; p < N_PORTS; p++) rx_cnt[p] = 0;
        test_reset();
        test_basic();
        test_parity_err();
        test_bad_addr();
        test_fill();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        summary_and_stop();
    end

endmodule
